// File: rtl/nmi_arbiter_pkg.sv
// Shared types and constants for the /NMI arbiter slice.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: none.
package nmi_arbiter_pkg;

  // Source index of each NMI requester (bit position in src_raw)
  typedef enum logic [1:0] {
    NMI_SRC_MAGIC  = 2'd0,
    NMI_SRC_PAUSE  = 2'd1,
    NMI_SRC_DIVMMC = 2'd2,
    NMI_SRC_KBD    = 2'd3
  } nmi_src_t;

  // Z80 NMI entry point; the M1 fetch of this address acknowledges the NMI
  localparam logic [15:0] NMI_VECTOR = 16'h0066;

  // Arbiter states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_INT = 2'd1,
    ST_ASSERT   = 2'd2,
    ST_SERVICE  = 2'd3
  } arb_state_t;

  // True on the opcode fetch of the NMI vector
  function automatic logic is_vector_fetch(input logic m1, input logic mreq,
                                           input logic [15:0] addr);
    return m1 && mreq && (addr == NMI_VECTOR);
  endfunction

endpackage

// File: rtl/nmi_arbiter_debounce.sv
// Synchronises one raw button and debounces it into a clean level plus a rise strobe.
// Latency: 2 sync cycles + 2**DEB_W-1 stable cycles before level changes; rise coincides with level 0->1.
// Backpressure: none; the input is sampled every cycle.
module button_debounce
  import nmi_arbiter_pkg::*;
#(
  parameter int DEB_W = 16
) (
  input  logic clk28,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  // Toggle on the last of 2**DEB_W-1 consecutive mismatch cycles
  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'((1 << DEB_W) - 2);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles where the synchronised input disagrees with the level
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser and debounce state
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/nmi_arbiter.sv
// Shares the Z80 /NMI line between NSRC debounced requesters with round-robin grant.
// Latency: /NMI falls 1 cycle after the INT-edge strobe, rises 1 cycle after the 0x0066 fetch.
// Backpressure: grants are held off while magic_mode is high; presses meanwhile stay pending.
module nmi_arbiter
  import nmi_arbiter_pkg::*;
#(
  parameter int NSRC  = 4,
  parameter int DEB_W = 16,
  parameter int TMO_W = 20
) (
  input  logic                    clk28,
  input  logic                    rst_n,
  input  logic [NSRC-1:0]         src_raw,
  input  logic                    n_int,
  input  logic                    n_int_next,
  input  logic                    bus_m1,
  input  logic                    bus_mreq,
  input  logic [15:0]             bus_a,
  input  logic                    magic_mode,
  output logic                    n_nmi,
  output logic [$clog2(NSRC)-1:0] nmi_cause,
  output logic [NSRC-1:0]         src_level,
  output logic                    tmo_flag
);

  localparam int               IW       = $clog2(NSRC);
  localparam logic [IW:0]      NSRC_W   = (IW + 1)'(NSRC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);

  logic [NSRC-1:0]  rise_vec;
  logic [NSRC-1:0]  pending_q, pending_d, clr_mask;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    cause_q, cause_d;
  logic [IW-1:0]    win;
  logic [IW:0]      cand;
  logic [IW:0]      rr_inc;
  logic             found;
  logic             ack;
  logic             n_nmi_q, n_nmi_d;
  logic             tmo_flag_q, tmo_flag_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  arb_state_t       state_q, state_d;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    button_debounce #(.DEB_W(DEB_W)) u_deb (
      .clk28 (clk28),
      .rst_n (rst_n),
      .raw   (src_raw[g]),
      .level (src_level[g]),
      .rise  (rise_vec[g])
    );
  end

  // Round-robin pick: first pending index at or after rr_ptr, wrapping at NSRC
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NSRC; k++) begin
      cand = {1'b0, rr_ptr_q} + (IW + 1)'(k);
      if (cand >= NSRC_W) begin
        cand = cand - NSRC_W;
      end
      if (!found && pending_q[cand[IW-1:0]]) begin
        win   = cand[IW-1:0];
        found = 1'b1;
      end
    end
  end

  // Arbiter FSM next state, /NMI drive, timeout and pending bookkeeping
  always_comb begin
    state_d    = state_q;
    n_nmi_d    = n_nmi_q;
    cause_d    = cause_q;
    tmo_flag_d = tmo_flag_q;
    tmo_cnt_d  = tmo_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    ack        = 1'b0;
    clr_mask   = '0;
    rr_inc     = {1'b0, cause_q} + 1'b1;
    if (rr_inc >= NSRC_W) begin
      rr_inc = '0;
    end
    case (state_q)
      ST_IDLE: begin
        if (found && !magic_mode) begin
          cause_d = win;
          state_d = ST_WAIT_INT;
        end
      end
      ST_WAIT_INT: begin
        if (!pending_q[cause_q]) begin
          state_d = ST_IDLE;
        end else if (n_int && !n_int_next) begin
          n_nmi_d   = 1'b0;
          tmo_cnt_d = '0;
          state_d   = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        // The vector fetch wins over a timeout landing in the same cycle
        if (is_vector_fetch(bus_m1, bus_mreq, bus_a)) begin
          n_nmi_d    = 1'b1;
          ack        = 1'b1;
          rr_ptr_d   = rr_inc[IW-1:0];
          tmo_flag_d = 1'b0;
          state_d    = ST_SERVICE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          n_nmi_d    = 1'b1;
          tmo_flag_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_SERVICE: begin
        if (!magic_mode) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (ack) begin
      clr_mask[cause_q] = 1'b1;
    end
    // A new press on the granted source in the ack cycle stays pending
    pending_d = (pending_q & ~clr_mask) | rise_vec;
  end

  // All arbiter state and registered outputs
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      n_nmi_q    <= 1'b1;
      cause_q    <= '0;
      tmo_flag_q <= 1'b0;
      tmo_cnt_q  <= '0;
      rr_ptr_q   <= '0;
      pending_q  <= '0;
    end else begin
      state_q    <= state_d;
      n_nmi_q    <= n_nmi_d;
      cause_q    <= cause_d;
      tmo_flag_q <= tmo_flag_d;
      tmo_cnt_q  <= tmo_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      pending_q  <= pending_d;
    end
  end

  assign n_nmi     = n_nmi_q;
  assign nmi_cause = cause_q;
  assign tmo_flag  = tmo_flag_q;

endmodule

// File: tb/tb_nmi_arbiter.sv
// Self-checking bench for nmi_arbiter with short debounce and timeout counters.
// Latency: drives on the falling edge, samples outputs on the falling edge.
// Backpressure: expected grant causes queue up at press time and are popped on each /NMI assertion.
module tb_nmi_arbiter;
  import nmi_arbiter_pkg::*;

  localparam int NSRC = 4;

  logic             clk28 = 1'b0;
  logic             rst_n;
  logic [NSRC-1:0]  src_raw;
  logic             n_int, n_int_next;
  logic             bus_m1, bus_mreq;
  logic [15:0]      bus_a;
  logic             magic_mode;
  logic             n_nmi;
  logic [1:0]       nmi_cause;
  logic [NSRC-1:0]  src_level;
  logic             tmo_flag;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_cause;

  always #5 clk28 = ~clk28;

  nmi_arbiter #(.NSRC(NSRC), .DEB_W(3), .TMO_W(6)) dut (
    .clk28      (clk28),
    .rst_n      (rst_n),
    .src_raw    (src_raw),
    .n_int      (n_int),
    .n_int_next (n_int_next),
    .bus_m1     (bus_m1),
    .bus_mreq   (bus_mreq),
    .bus_a      (bus_a),
    .magic_mode (magic_mode),
    .n_nmi      (n_nmi),
    .nmi_cause  (nmi_cause),
    .src_level  (src_level),
    .tmo_flag   (tmo_flag)
  );

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk28);
  endtask

  // One-cycle INT falling-edge lookahead strobe; returns on the following falling edge
  task automatic int_strobe();
    @(negedge clk28);
    n_int_next = 1'b0;
    @(negedge clk28);
    n_int_next = 1'b1;
  endtask

  // One-cycle M1 opcode fetch at addr
  task automatic fetch(input logic [15:0] addr);
    @(negedge clk28);
    bus_m1 = 1'b1; bus_mreq = 1'b1; bus_a = addr;
    @(negedge clk28);
    bus_m1 = 1'b0; bus_mreq = 1'b0; bus_a = 16'h0000;
  endtask

  // Clean press and release of every source in mask, long enough to debounce both edges
  task automatic press(input logic [NSRC-1:0] mask);
    @(negedge clk28);
    src_raw = src_raw | mask;
    wait_cyc(12);
    src_raw = src_raw & ~mask;
    wait_cyc(12);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cyc(3);
    n_cmp++; if (n_nmi !== 1'b1) begin n_bad++; $display("FAIL reset_n_nmi: got %b want 1", n_nmi); end
    n_cmp++; if (nmi_cause !== 2'd0) begin n_bad++; $display("FAIL reset_cause: got %0d want 0", nmi_cause); end
    n_cmp++; if (src_level !== 4'b0000) begin n_bad++; $display("FAIL reset_level: got %b want 0000", src_level); end
    n_cmp++; if (tmo_flag !== 1'b0) begin n_bad++; $display("FAIL reset_tmo: got %b want 0", tmo_flag); end
    rst_n = 1'b1;
    wait_cyc(2);
  endtask

  task automatic test_debounce();
    logic rose_early = 1'b0;
    int   cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk28);
      if (src_level[0] !== 1'b0) rose_early = 1'b1;
      src_raw[0] = (((i / 3) % 2) == 0);
    end
    n_cmp++; if (rose_early !== 1'b0) begin n_bad++; $display("FAIL deb_bounce: level rose during bouncing"); end
    @(negedge clk28);
    src_raw[0] = 1'b1;
    exp_q.push_back(NMI_SRC_MAGIC);
    while (src_level[0] !== 1'b1 && cnt < 30) begin
      @(negedge clk28);
      cnt++;
    end
    n_cmp++; if (cnt != 9) begin n_bad++; $display("FAIL deb_settle: level rose after %0d cycles want 9", cnt); end
    wait_cyc(3);
    int_strobe();
    exp_cause = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
    n_cmp++; if (n_nmi !== 1'b0) begin n_bad++; $display("FAIL deb_assert: n_nmi %b want 0", n_nmi); end
    n_cmp++; if (nmi_cause !== exp_cause) begin n_bad++; $display("FAIL deb_cause: got %0d want %0d", nmi_cause, exp_cause); end
    fetch(NMI_VECTOR);
    n_cmp++; if (n_nmi !== 1'b1) begin n_bad++; $display("FAIL deb_release: n_nmi %b want 1", n_nmi); end
    src_raw[0] = 1'b0;
    wait_cyc(12);
    int_strobe();
    n_cmp++; if (n_nmi !== 1'b1) begin n_bad++; $display("FAIL deb_single_pending: n_nmi %b want 1", n_nmi); end
  endtask

  task automatic test_round_robin();
    exp_q.push_back(NMI_SRC_DIVMMC);
    exp_q.push_back(NMI_SRC_MAGIC);
    press(4'b0101);
    int_strobe();
    exp_cause = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
    n_cmp++; if (n_nmi !== 1'b0) begin n_bad++; $display("FAIL rr_first_assert: n_nmi %b want 0", n_nmi); end
    n_cmp++; if (nmi_cause !== exp_cause) begin n_bad++; $display("FAIL rr_first_cause: got %0d want %0d", nmi_cause, exp_cause); end
    magic_mode = 1'b1;
    fetch(NMI_VECTOR);
    n_cmp++; if (n_nmi !== 1'b1) begin n_bad++; $display("FAIL rr_first_release: n_nmi %b want 1", n_nmi); end
    int_strobe();
    n_cmp++; if (n_nmi !== 1'b1) begin n_bad++; $display("FAIL rr_service_hold: n_nmi %b want 1", n_nmi); end
    magic_mode = 1'b0;
    wait_cyc(3);
    int_strobe();
    exp_cause = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
    n_cmp++; if (n_nmi !== 1'b0) begin n_bad++; $display("FAIL rr_second_assert: n_nmi %b want 0", n_nmi); end
    n_cmp++; if (nmi_cause !== exp_cause) begin n_bad++; $display("FAIL rr_second_cause: got %0d want %0d", nmi_cause, exp_cause); end
    fetch(NMI_VECTOR);
    n_cmp++; if (n_nmi !== 1'b1) begin n_bad++; $display("FAIL rr_second_release: n_nmi %b want 1", n_nmi); end
  endtask

  task automatic test_basic_pause();
    exp_q.push_back(NMI_SRC_PAUSE);
    press(4'b0010);
    n_cmp++; if (n_nmi !== 1'b1) begin n_bad++; $display("FAIL basic_pre_strobe: n_nmi %b want 1", n_nmi); end
    int_strobe();
    exp_cause = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
    n_cmp++; if (n_nmi !== 1'b0) begin n_bad++; $display("FAIL basic_assert: n_nmi %b want 0", n_nmi); end
    n_cmp++; if (nmi_cause !== exp_cause) begin n_bad++; $display("FAIL basic_cause: got %0d want %0d", nmi_cause, exp_cause); end
    fetch(16'h0038);
    n_cmp++; if (n_nmi !== 1'b0) begin n_bad++; $display("FAIL basic_wrong_addr: n_nmi %b want 0", n_nmi); end
    fetch(NMI_VECTOR);
    n_cmp++; if (n_nmi !== 1'b1) begin n_bad++; $display("FAIL basic_release: n_nmi %b want 1", n_nmi); end
  endtask

  task automatic test_block();
    magic_mode = 1'b1;
    exp_q.push_back(NMI_SRC_KBD);
    press(4'b1000);
    for (int i = 0; i < 2; i++) begin
      int_strobe();
      n_cmp++; if (n_nmi !== 1'b1) begin n_bad++; $display("FAIL block_hold_%0d: n_nmi %b want 1", i, n_nmi); end
    end
    magic_mode = 1'b0;
    wait_cyc(3);
    int_strobe();
    exp_cause = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
    n_cmp++; if (n_nmi !== 1'b0) begin n_bad++; $display("FAIL block_assert: n_nmi %b want 0", n_nmi); end
    n_cmp++; if (nmi_cause !== exp_cause) begin n_bad++; $display("FAIL block_cause: got %0d want %0d", nmi_cause, exp_cause); end
    fetch(NMI_VECTOR);
    n_cmp++; if (n_nmi !== 1'b1) begin n_bad++; $display("FAIL block_release: n_nmi %b want 1", n_nmi); end
  endtask

  task automatic test_timeout();
    int cnt = 1;
    exp_q.push_back(NMI_SRC_DIVMMC);
    exp_q.push_back(NMI_SRC_DIVMMC);
    press(4'b0100);
    int_strobe();
    exp_cause = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
    n_cmp++; if (n_nmi !== 1'b0) begin n_bad++; $display("FAIL tmo_assert: n_nmi %b want 0", n_nmi); end
    n_cmp++; if (nmi_cause !== exp_cause) begin n_bad++; $display("FAIL tmo_cause: got %0d want %0d", nmi_cause, exp_cause); end
    while (n_nmi === 1'b0 && cnt < 200) begin
      @(negedge clk28);
      if (n_nmi === 1'b0) cnt++;
    end
    n_cmp++; if (cnt != 63) begin n_bad++; $display("FAIL tmo_low_cycles: got %0d want 63", cnt); end
    n_cmp++; if (tmo_flag !== 1'b1) begin n_bad++; $display("FAIL tmo_flag_set: got %b want 1", tmo_flag); end
    wait_cyc(3);
    int_strobe();
    exp_cause = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
    n_cmp++; if (n_nmi !== 1'b0) begin n_bad++; $display("FAIL tmo_reassert: n_nmi %b want 0", n_nmi); end
    n_cmp++; if (nmi_cause !== exp_cause) begin n_bad++; $display("FAIL tmo_reassert_cause: got %0d want %0d", nmi_cause, exp_cause); end
    n_cmp++; if (tmo_flag !== 1'b1) begin n_bad++; $display("FAIL tmo_flag_sticky: got %b want 1", tmo_flag); end
    fetch(NMI_VECTOR);
    n_cmp++; if (n_nmi !== 1'b1) begin n_bad++; $display("FAIL tmo_ack_release: n_nmi %b want 1", n_nmi); end
    n_cmp++; if (tmo_flag !== 1'b0) begin n_bad++; $display("FAIL tmo_flag_clear: got %b want 0", tmo_flag); end
  endtask

  task automatic test_reset_in_assert();
    exp_q.push_back(NMI_SRC_MAGIC);
    @(negedge clk28);
    src_raw[0] = 1'b1;
    wait_cyc(12);
    n_cmp++; if (src_level[0] !== 1'b1) begin n_bad++; $display("FAIL rst_pre_level: got %b want 1", src_level[0]); end
    int_strobe();
    exp_cause = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
    n_cmp++; if (n_nmi !== 1'b0) begin n_bad++; $display("FAIL rst_pre_assert: n_nmi %b want 0", n_nmi); end
    n_cmp++; if (nmi_cause !== exp_cause) begin n_bad++; $display("FAIL rst_pre_cause: got %0d want %0d", nmi_cause, exp_cause); end
    @(negedge clk28);
    rst_n = 1'b0;
    src_raw[0] = 1'b0;
    @(negedge clk28);
    rst_n = 1'b1;
    n_cmp++; if (n_nmi !== 1'b1) begin n_bad++; $display("FAIL rst_n_nmi: got %b want 1", n_nmi); end
    n_cmp++; if (src_level !== 4'b0000) begin n_bad++; $display("FAIL rst_level: got %b want 0000", src_level); end
    n_cmp++; if (nmi_cause !== 2'd0) begin n_bad++; $display("FAIL rst_cause: got %0d want 0", nmi_cause); end
    wait_cyc(12);
    int_strobe();
    n_cmp++; if (n_nmi !== 1'b1) begin n_bad++; $display("FAIL rst_pending_cleared: n_nmi %b want 1", n_nmi); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    src_raw    = '0;
    n_int      = 1'b1;
    n_int_next = 1'b1;
    bus_m1     = 1'b0;
    bus_mreq   = 1'b0;
    bus_a      = 16'h0000;
    magic_mode = 1'b0;
    test_reset();
    test_debounce();
    test_round_robin();
    test_basic_pause();
    test_block();
    test_timeout();
    test_reset_in_assert();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
